mm3_argmax_reader: RTL and testbench
====================================

Name: mm3_argmax_reader

Overview:
- Read-side sequencer for the layer-3 output memory (1x32 array of signed 32-bit logits).
- On a start pulse, scans NUM_ENTRIES consecutive words starting at BASE_ADDR by driving the memory read address.
- Returns the index and value of the largest signed entry as the network's classification result.
- Sits between the mm3 output memory and the result/display logic. It never writes the memory.

Parameters:
- NUM_ENTRIES, 10, number of words scanned; legal range 1..32, with BASE_ADDR+NUM_ENTRIES <= 32.
- BASE_ADDR, 0, first memory address scanned.
- ADDR_WIDTH, 16, width of the memory read address.
- DATA_WIDTH, 32, width of a memory word, two's-complement signed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  scan request, sampled on the rising edge; honoured only in IDLE.
- read_addr  output  ADDR_WIDTH  registered address to the memory read port.
- read_data  input  DATA_WIDTH  signed word from the memory; combinational function of read_addr, valid in the same cycle.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when results are updated.
- max_index  output  ADDR_WIDTH  offset (0..NUM_ENTRIES-1, relative to BASE_ADDR) of the maximum entry.
- max_value  output  DATA_WIDTH  signed value of the maximum entry.

Behaviour:
- Reset (synchronous, any state):
  - state goes to IDLE; read_addr=BASE_ADDR; busy=0; done=0; max_index=0; max_value=0.
  - Internal count and running max are cleared.
  - Reset mid-scan abandons the scan with no done pulse.
- FSM states: IDLE, SCAN.
- IDLE:
  - busy=0; read_addr is held at BASE_ADDR.
  - Edge with start=1 moves to SCAN with count=0 and read_addr=BASE_ADDR.
- SCAN:
  - busy=1.
  - Each edge samples read_data, which corresponds to read_addr=BASE_ADDR+count.
  - count=0: the running max is loaded unconditionally (value=read_data, index=0).
  - count>0: the running max is replaced only if read_data > running value (signed, strict).
  - Ties keep the lower index.
  - If count<NUM_ENTRIES-1: count and read_addr each increment by 1.
  - If count==NUM_ENTRIES-1:
    - max_index and max_value are loaded with the final result, including the current sample's comparison.
    - done=1 for the following cycle; state returns to IDLE; read_addr returns to BASE_ADDR.
- Latency: start is sampled at edge E0; done is high in the cycle after edge E0+NUM_ENTRIES, i.e. exactly NUM_ENTRIES edges after acceptance. A scan occupies NUM_ENTRIES cycles of busy.
- start while busy is ignored; it is not queued.
- start asserted in the done cycle: accepted, because state is IDLE, so back-to-back scans run with no gap.
- max_index and max_value hold their previous result throughout a new scan and change only at completion.
- Comparison is full-width signed. Both 0x80000000 and 0x7FFFFFFF must order correctly; there are no overflow paths.
- NUM_ENTRIES=1: single SCAN cycle; done one edge later; max_index=0.
- read_addr never exceeds BASE_ADDR+NUM_ENTRIES-1.

Test Plan:
- Memory words 0..9 = {5,-3,12,7,12,0,-100,11,2,1}, pulse start: busy for 10 cycles, read_addr steps 0..9. done pulses exactly 10 edges after the start edge with max_index=2 and max_value=12 (tie with index 4 keeps 2).
- All ten entries negative {-50,-7,-8,...,-0x80000000}: max_index=1, max_value=-7. Confirms first-entry load and signed compare; the result is not 0.
- Entry 9 = 0x7FFFFFFF, entry 0 = 0x80000000, others 0: max_index=9, max_value=0x7FFFFFFF.
- Assert start again 3 cycles into a scan, then reassert start in the done cycle: the first request is ignored. The second scan starts immediately and is accepted; the previous result stays stable until the second done.
- Assert reset 5 cycles into a scan: next cycle busy=0, done=0, read_addr=0, max_index=0, max_value=0. No done pulse follows; a subsequent start completes normally.
- NUM_ENTRIES=1, BASE_ADDR=31, memory[31]=-4: read_addr=31; done one edge after start; max_index=0, max_value=-4.

Source files
------------

// File: rtl/mm3_argmax_reader.sv
// mm3_argmax_reader
// Read-side sequencer for the layer-3 output memory. On a start pulse it walks
// NUM_ENTRIES consecutive words beginning at BASE_ADDR. It keeps a running
// signed maximum and publishes the offset and value of the largest entry.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   start      scan request, honoured only while idle
//   read_addr  registered memory read address
//   read_data  signed memory word for read_addr (same-cycle combinational read)
//   busy       high for the NUM_ENTRIES cycles of a scan
//   done       one-cycle pulse when max_index/max_value are refreshed
//   max_index  offset of the maximum entry relative to BASE_ADDR
//   max_value  signed value of the maximum entry
module mm3_argmax_reader #(
    parameter int NUM_ENTRIES = 10,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] max_index,
    output logic [DATA_WIDTH-1:0] max_value
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_CNT  = ADDR_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   count_r;
    logic [ADDR_WIDTH-1:0]   read_addr_r;
    logic                    busy_r;
    logic                    done_r;
    logic [ADDR_WIDTH-1:0]   max_index_r;
    logic [DATA_WIDTH-1:0]   max_value_r;
    logic [ADDR_WIDTH-1:0]   run_idx_r;
    logic [DATA_WIDTH-1:0]   run_val_r;

    logic                    take_s;
    logic [ADDR_WIDTH-1:0]   next_idx_s;
    logic [DATA_WIDTH-1:0]   next_val_s;

    assign read_addr = read_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign max_index = max_index_r;
    assign max_value = max_value_r;

    // Decide whether the current sample replaces the running maximum.
    // The first sample always loads; later ones need a strictly greater
    // signed value so that ties keep the lower index.
    always_comb begin
        take_s = 1'b0;
        if (count_r == ADDR_ZERO) begin
            take_s = 1'b1;
        end else if ($signed(read_data) > $signed(run_val_r)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Running maximum after folding in the current sample.
    always_comb begin
        next_idx_s = run_idx_r;
        next_val_s = run_val_r;
        if (take_s) begin
            next_idx_s = count_r;
            next_val_s = read_data;
        end else begin
            next_idx_s = run_idx_r;
            next_val_s = run_val_r;
        end
    end

    // Scan sequencer: address stepping, running max and result publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= ADDR_ZERO;
            read_addr_r <= ADDR_BASE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            max_index_r <= ADDR_ZERO;
            max_value_r <= DATA_ZERO;
            run_idx_r   <= ADDR_ZERO;
            run_val_r   <= DATA_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r      <= 1'b0;
                    count_r     <= ADDR_ZERO;
                    read_addr_r <= ADDR_BASE;
                    if (start) begin
                        state_r <= ST_SCAN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    run_idx_r <= next_idx_s;
                    run_val_r <= next_val_s;
                    if (count_r == LAST_CNT) begin
                        // Final sample: publish including this sample's compare.
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        count_r     <= ADDR_ZERO;
                        read_addr_r <= ADDR_BASE;
                        max_index_r <= next_idx_s;
                        max_value_r <= next_val_s;
                    end else begin
                        state_r     <= ST_SCAN;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        count_r     <= count_r + ADDR_ONE;
                        read_addr_r <= read_addr_r + ADDR_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= ADDR_ZERO;
                    read_addr_r <= ADDR_BASE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm3_argmax_reader.sv
// Self-checking bench for mm3_argmax_reader. Instance A uses the default
// geometry (10 entries from address 0); instance B covers a one-entry scan at
// the top of the memory. Instance A results go through a scoreboard queue that
// a negedge monitor drains whenever done pulses.
module tb_mm3_argmax_reader;

    localparam int N_A    = 10;
    localparam int BASE_A = 0;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] read_addr;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic [15:0] max_index;
    logic [31:0] max_value;

    logic        b_reset;
    logic        b_start;
    logic [15:0] b_read_addr;
    logic [31:0] b_read_data;
    logic        b_busy;
    logic        b_done;
    logic [15:0] b_max_index;
    logic [31:0] b_max_value;

    logic [31:0] mem [0:31];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [15:0] idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] held_idx = 16'd0;
    logic [31:0] held_val = 32'd0;
    int          busy_cnt = 0;
    bit          armed    = 1'b0;

    mm3_argmax_reader #(
        .NUM_ENTRIES(N_A), .BASE_ADDR(BASE_A), .ADDR_WIDTH(16), .DATA_WIDTH(32)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .read_addr(read_addr),
        .read_data(read_data), .busy(busy), .done(done),
        .max_index(max_index), .max_value(max_value)
    );

    mm3_argmax_reader #(
        .NUM_ENTRIES(1), .BASE_ADDR(31), .ADDR_WIDTH(16), .DATA_WIDTH(32)
    ) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .read_addr(b_read_addr),
        .read_data(b_read_data), .busy(b_busy), .done(b_done),
        .max_index(b_max_index), .max_value(b_max_value)
    );

    assign read_data   = mem[read_addr[4:0]];
    assign b_read_data = (b_read_addr == 16'd31) ? 32'hFFFF_FFFC : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares results on done, checks held outputs and
    // address stepping on every other cycle.
    always @(negedge clk) begin
        if (armed) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.due));
                    chk("busy_cycles", 32'(busy_cnt), 32'(N_A));
                    chk("max_index", 32'(max_index), 32'(e.idx));
                    chk("max_value", max_value, e.val);
                    held_idx = e.idx;
                    held_val = e.val;
                end
                chk("busy_in_done", 32'(busy), 32'd0);
                busy_cnt = 0;
            end else begin
                chk("held_index", 32'(max_index), 32'(held_idx));
                chk("held_value", max_value, held_val);
                if (busy) begin
                    chk("scan_addr", 32'(read_addr), 32'(BASE_A + busy_cnt));
                    busy_cnt++;
                end else begin
                    chk("idle_addr", 32'(read_addr), 32'(BASE_A));
                end
            end
        end
        if (reset) begin
            armed = 1'b1;
            sb_q.delete();
            held_idx = 16'd0;
            held_val = 32'd0;
            busy_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge and queue the result that scan must produce.
    task automatic do_start(input logic [15:0] idx, input logic [31:0] val);
        exp_t e;
        start = 1'b1;
        tick();
        start = 1'b0;
        e.due = cyc + N_A;
        e.idx = idx;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            chk({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic load_mem(input logic [31:0] v [0:9]);
        for (int i = 0; i < 10; i++) mem[i] = v[i];
    endtask

    logic [31:0] vec [0:9];
    int          c0;

    initial begin
        reset   = 1'b1;
        b_reset = 1'b1;
        start   = 1'b0;
        b_start = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        repeat (3) tick();
        reset   = 1'b0;
        b_reset = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(read_addr), 32'd0);
        chk("rst_index", 32'(max_index), 32'd0);
        chk("rst_value", max_value, 32'd0);

        // Mixed values with a tie at index 4: expect index 2, value 12.
        vec = '{32'd5, -32'sd3, 32'd12, 32'd7, 32'd12, 32'd0, -32'sd100, 32'd11, 32'd2, 32'd1};
        load_mem(vec);
        do_start(16'd2, 32'd12);
        wait_idle("mixed");
        tick();

        // All negative: expect index 1, value -7.
        vec = '{-32'sd50, -32'sd7, -32'sd8, -32'sd9, -32'sd10, -32'sd11, -32'sd12,
                -32'sd13, -32'sd14, 32'h8000_0000};
        load_mem(vec);
        do_start(16'd1, 32'hFFFF_FFF9);
        wait_idle("negative");
        tick();

        // Extremes: most negative at 0, most positive at 9.
        vec = '{32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
        load_mem(vec);
        do_start(16'd9, 32'h7FFF_FFFF);
        wait_idle("extremes");
        tick();

        // Ignored start mid-scan, then back-to-back start in the done cycle.
        vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, -32'sd1};
        load_mem(vec);
        do_start(16'd8, 32'd9);
        c0 = cyc;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && cyc != c0 + N_A; k++) tick();
        chk("b2b_done_cycle", 32'(done), 32'd1);
        do_start(16'd8, 32'd9);
        wait_idle("back_to_back");
        tick();

        // Reset five cycles into a scan abandons it.
        vec = '{32'd5, -32'sd3, 32'd12, 32'd7, 32'd12, 32'd0, -32'sd100, 32'd11, 32'd2, 32'd1};
        load_mem(vec);
        do_start(16'd2, 32'd12);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", 32'(read_addr), 32'd0);
        chk("abort_index", 32'(max_index), 32'd0);
        chk("abort_value", max_value, 32'd0);
        repeat (15) tick();
        do_start(16'd2, 32'd12);
        wait_idle("after_abort");
        tick();

        // One-entry scan at address 31.
        @(negedge clk);
        chk("b_idle_addr", 32'(b_read_addr), 32'd31);
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        @(negedge clk);
        chk("b_busy", 32'(b_busy), 32'd1);
        chk("b_scan_addr", 32'(b_read_addr), 32'd31);
        chk("b_no_done_yet", 32'(b_done), 32'd0);
        @(negedge clk);
        chk("b_done", 32'(b_done), 32'd1);
        chk("b_busy_low", 32'(b_busy), 32'd0);
        chk("b_index", 32'(b_max_index), 32'd0);
        chk("b_value", b_max_value, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("b_done_pulse", 32'(b_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
